// File: rtl/bk_add_arb_pkg.sv
// Shared definitions for the time-multiplexed Brent-Kung add/sub arbiter.
package bk_add_arb_pkg;

   localparam int unsigned SliceW    = 16;
   localparam int unsigned DefSlices = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/bk_slice16.sv
// Combinational 16-bit Brent-Kung adder with carry-in.
module bk_slice16
   import bk_add_arb_pkg::*;
(
   input  logic [SliceW-1:0] a,
   input  logic [SliceW-1:0] b,
   input  logic              cin,
   output logic [SliceW-1:0] sum,
   output logic              cout
);

   logic [SliceW-1:0] p;
   logic [SliceW-1:0] gg;
   logic [SliceW-1:0] pg;
   logic [SliceW-1:0] c;

   always_comb begin
      p  = a ^ b;
      gg = a & b;
      pg = p;
      // Carry-in folds into bit 0 so every prefix below already includes it.
      gg[0] = gg[0] | (p[0] & cin);

      for (int lvl = 0; lvl < 4; lvl++) begin
         for (int i = 0; i < SliceW; i++) begin
            if (((i + 1) % (2 << lvl)) == 0) begin
               gg[i] = gg[i] | (pg[i] & gg[i - (1 << lvl)]);
               pg[i] = pg[i] & pg[i - (1 << lvl)];
            end
         end
      end

      for (int lvl = 2; lvl >= 0; lvl--) begin
         for (int i = 0; i < SliceW; i++) begin
            if ((((i + 1) % (2 << lvl)) == (1 << lvl)) && (i >= (2 << lvl))) begin
               gg[i] = gg[i] | (pg[i] & gg[i - (1 << lvl)]);
               pg[i] = pg[i] & pg[i - (1 << lvl)];
            end
         end
      end

      c    = {gg[SliceW-2:0], cin};
      sum  = p ^ c;
      cout = gg[SliceW-1];
   end

endmodule

// File: rtl/bk_add_arb.sv
// Two-requester round-robin front end sharing one 16-bit Brent-Kung slice,
// evaluated LSB slice first over SLICES cycles per operation.
module bk_add_arb
   import bk_add_arb_pkg::*;
#(
   parameter  int unsigned NREQ   = 2,
   parameter  int unsigned SLICES = DefSlices,
   localparam int unsigned W      = SliceW * SLICES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_sub,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [W-1:0]      rsp_sum,
   output logic              rsp_cout
);

   localparam int unsigned CntW = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(SLICES - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              prio_q, prio_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              sub_q, sub_d;
   logic              id_q, id_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d;

   logic              gnt;
   logic [SliceW-1:0] sl_a, sl_b, sl_sum;
   logic              sl_cout;

   assign sl_a = a_q[int'(cnt_q)*SliceW +: SliceW];
   assign sl_b = b_q[int'(cnt_q)*SliceW +: SliceW] ^ {SliceW{sub_q}};

   bk_slice16 u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prio_d    = prio_q;
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      id_d      = id_q;
      carry_d   = carry_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      req_ready = '0;
      gnt       = req_valid[prio_q] ? prio_q : ~prio_q;

      case (state_q)
         StIdle: begin
            if (|req_valid) begin
               // Gated by rst_n so no accept is ever signalled while reset is held.
               req_ready[gnt] = rst_n;
               a_d     = req_a[int'(gnt)*W +: W];
               b_d     = req_b[int'(gnt)*W +: W];
               sub_d   = req_sub[gnt];
               carry_d = req_sub[gnt];
               id_d    = gnt;
               prio_d  = ~gnt;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d[int'(cnt_q)*SliceW +: SliceW] = sl_sum;
            carry_d = sl_cout;
            if (cnt_q == LastCnt) begin
               cout_d  = sl_cout;
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         prio_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         id_q    <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         id_q    <= id_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign rsp_valid = (state_q == StDone);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_bk_add_arb.sv
// Directed-vector and scenario bench for bk_add_arb.
module tb_bk_add_arb;

   localparam int W = 64;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_a;
   logic [2*W-1:0] req_b;
   logic [1:0]     req_sub;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [W-1:0]   rsp_sum;
   logic           rsp_cout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bk_add_arb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
   endtask

   // Single-requester operation from IDLE; checks grant, latency and payload.
   task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] esum, input logic ecout,
                         input string name);
      int lat;
      @(negedge clk);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_sub[id]      = sub;
      req_valid        = 2'b00;
      req_valid[id]    = 1'b1;
      rsp_ready        = 1'b1;
      #1;
      check({name, " ready"}, W'(req_ready), W'(2'b01 << id));
      @(posedge clk);
      #1 req_valid = 2'b00;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      check({name, " latency"}, W'(lat), W'(5));
      check({name, " id"}, W'(rsp_id), W'(id));
      check({name, " sum"}, rsp_sum, esum);
      check({name, " cout"}, W'(rsp_cout), W'(ecout));
      @(posedge clk);
   endtask

   initial begin
      int           gids[4];
      int           gcyc[4];
      int           n;
      int           seen;
      logic [W-1:0] ra, rb, bx;
      logic         rs;
      int           rid;
      logic [W:0]   ref_r;

      vecs[0] = '{0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
      vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
      vecs[2] = '{1, 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[3] = '{1, 64'h7, 64'h5, 1'b1, 64'h2, 1'b1};
      vecs[4] = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
      vecs[5] = '{1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                  64'h2222_2222_2222_2211, 1'b0};
      vecs[6] = '{0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0, 1'b1};
      vecs[7] = '{1, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

      req_valid = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_sub   = 2'b00;
      rsp_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);

      // While reset is held, a pending request must not see ready.
      req_valid = 2'b11;
      #1;
      check("reset ready", W'(req_ready), W'(0));
      req_valid = 2'b00;
      rst_n     = 1'b1;
      #1;
      check("reset rsp_valid", W'(rsp_valid), W'(0));
      check("reset rsp_sum", rsp_sum, W'(0));
      check("reset rsp_cout", W'(rsp_cout), W'(0));
      check("reset rsp_id", W'(rsp_id), W'(0));

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout,
                $sformatf("vec%0d", i));
      end

      // Contention: both requesters held valid from a fresh reset.
      @(negedge clk);
      do_reset();
      req_a     = {64'h10, 64'h20};
      req_b     = {64'h1, 64'h2};
      req_sub   = 2'b00;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 60; k++) begin
         #1;
         if (req_ready != 2'b00) begin
            gids[n] = int'(req_ready[1]);
            gcyc[n] = cyc;
            n++;
         end
         if (n == 4) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      check("contention grants", W'(n), W'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < n) begin
            check($sformatf("contention grant%0d", i), W'(gids[i]), W'(i % 2));
            if (i > 0) check($sformatf("contention gap%0d", i), W'(gcyc[i] - gcyc[i-1]), W'(6));
         end
      end
      drain();

      // Backpressure in DONE.
      @(negedge clk);
      rsp_ready = 1'b0;
      req_a[0 +: W] = 64'h1111_1111_1111_1111;
      req_b[0 +: W] = 64'h2222_2222_2222_2222;
      req_sub   = 2'b00;
      req_valid = 2'b01;
      @(posedge clk);
      #1 req_valid = 2'b00;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      req_valid = 2'b10;
      for (int k = 0; k < 10; k++) begin
         #1;
         check($sformatf("bp hold%0d", k),
               W'(rsp_valid && (req_ready == 2'b00) && !rsp_cout && !rsp_id &&
                  (rsp_sum == 64'h3333_3333_3333_3333)), W'(1));
         @(negedge clk);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp release", W'(rsp_valid), W'(0));

      // Reset during slice 2 after requester 0 was granted last.
      req_a[0 +: W] = 64'h0001_0001_0001_0001;
      req_b[0 +: W] = 64'h0001_0001_0001_0001;
      req_valid = 2'b01;
      @(posedge clk);
      #1 req_valid = 2'b11;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun rsp_valid", W'(rsp_valid), W'(0));
      check("midrun ready", W'(req_ready), W'(0));
      check("midrun rsp_sum", rsp_sum, W'(0));
      check("midrun rsp_cout", W'(rsp_cout), W'(0));
      check("midrun rsp_id", W'(rsp_id), W'(0));
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("midrun no rsp", W'(seen), W'(0));
      req_valid = 2'b11;
      #1;
      check("midrun next grant", W'(req_ready), W'(2'b01));
      @(posedge clk);
      #1 req_valid = 2'b00;
      drain();

      // Random operations against a 65-bit reference.
      for (int i = 0; i < 4000; i++) begin
         ra    = {$urandom, $urandom};
         rb    = {$urandom, $urandom};
         rs    = 1'($urandom_range(0, 1));
         rid   = int'($urandom_range(0, 1));
         bx    = rs ? ~rb : rb;
         ref_r = {1'b0, ra} + {1'b0, bx} + {{W{1'b0}}, rs};
         run_op(rid, ra, rb, rs, ref_r[W-1:0], ref_r[W], $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
